// File: rtl/prog_mem_loadable.sv
// prog_mem_loadable: Jac1-8 program memory. It is cleared to NOP after reset and
// written at run time by a streaming loader that packs beats MSB-first into words.
module prog_mem_loadable #(
    parameter int PC_WIDTH = 8,
    parameter int IR_WIDTH = 16,
    parameter int CMD_CNT  = 64,
    parameter int LD_WIDTH = 8,
    parameter int REG_READ = 0
) (
    input  logic                clk,
    input  logic                res,
    input  logic [PC_WIDTH-1:0] pc,
    output logic [IR_WIDTH-1:0] ir,
    output logic                ir_valid,
    output logic                busy,
    input  logic                ld_start,
    input  logic [PC_WIDTH-1:0] ld_addr,
    input  logic                ld_valid,
    output logic                ld_ready,
    input  logic [LD_WIDTH-1:0] ld_data,
    input  logic                ld_last,
    output logic                ld_done,
    output logic                ld_err
);
    localparam int BPW = IR_WIDTH / LD_WIDTH;
    localparam int BW  = BPW > 1 ? $clog2(BPW) : 1;
    localparam int AW  = CMD_CNT > 1 ? $clog2(CMD_CNT) : 1;
    localparam logic [PC_WIDTH:0] CNT       = (PC_WIDTH+1)'(CMD_CNT);
    localparam logic [BW-1:0]     LAST_BEAT = BW'(BPW - 1);
    localparam logic [AW-1:0]     LAST_CLR  = AW'(CMD_CNT - 1);
    localparam logic [1:0] S_CLEAR = 2'd0, S_IDLE = 2'd1, S_LOAD = 2'd2, S_DRAIN = 2'd3;

    logic [IR_WIDTH-1:0] mem [CMD_CNT];
    logic [1:0]          state_q, state_d;
    logic [AW-1:0]       clr_addr_q, clr_addr_d;
    logic [PC_WIDTH:0]   wr_addr_q, wr_addr_d;
    logic [BW-1:0]       beat_q, beat_d;
    logic [IR_WIDTH-1:0] word_q, word_d;
    logic                ld_done_q, ld_done_d, ld_err_q, ld_err_d;
    logic                xfer, word_end, overflow, start_bad, we;
    logic [AW-1:0]       we_addr;
    logic [IR_WIDTH-1:0] we_data, shifted, ir_c;

    assign busy      = state_q != S_IDLE;
    assign ld_ready  = state_q == S_LOAD || state_q == S_DRAIN;
    assign ld_done   = ld_done_q;
    assign ld_err    = ld_err_q;
    assign xfer      = ld_valid && ld_ready;
    assign shifted   = (word_q << LD_WIDTH) | IR_WIDTH'(ld_data);
    // wr_addr carries one extra bit so stepping past the last word is visible
    assign overflow  = wr_addr_q >= CNT;
    assign word_end  = beat_q == LAST_BEAT;
    assign start_bad = {1'b0, ld_addr} >= CNT;
    assign we        = state_q == S_CLEAR || (state_q == S_LOAD && xfer && !overflow && word_end);
    assign we_addr   = state_q == S_CLEAR ? clr_addr_q : wr_addr_q[AW-1:0];
    assign we_data   = state_q == S_CLEAR ? '0 : shifted;

    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        wr_addr_d  = wr_addr_q;
        beat_d     = beat_q;
        word_d     = word_q;
        ld_done_d  = 1'b0;
        ld_err_d   = ld_err_q;
        case (state_q)
            S_CLEAR: begin
                clr_addr_d = clr_addr_q == LAST_CLR ? '0 : clr_addr_q + 1'b1;
                state_d    = clr_addr_q == LAST_CLR ? S_IDLE : S_CLEAR;
            end
            S_IDLE: if (ld_start) begin
                wr_addr_d = {1'b0, ld_addr};
                beat_d    = '0;
                ld_err_d  = start_bad;
                state_d   = start_bad ? S_DRAIN : S_LOAD;
            end
            S_LOAD: if (xfer) begin
                if (overflow) begin
                    ld_err_d  = 1'b1;
                    ld_done_d = ld_last;
                    state_d   = ld_last ? S_IDLE : S_DRAIN;
                end else begin
                    word_d    = shifted;
                    beat_d    = word_end ? '0 : beat_q + 1'b1;
                    wr_addr_d = word_end ? wr_addr_q + 1'b1 : wr_addr_q;
                    ld_done_d = ld_last;
                    ld_err_d  = ld_err_q || (ld_last && !word_end);
                    state_d   = ld_last ? S_IDLE : S_LOAD;
                end
            end
            default: if (xfer && ld_last) begin
                ld_done_d = 1'b1;
                state_d   = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (res) begin
            state_q    <= S_CLEAR;
            clr_addr_q <= '0;
            wr_addr_q  <= '0;
            beat_q     <= '0;
            word_q     <= '0;
            ld_done_q  <= 1'b0;
            ld_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
            wr_addr_q  <= wr_addr_d;
            beat_q     <= beat_d;
            word_q     <= word_d;
            ld_done_q  <= ld_done_d;
            ld_err_q   <= ld_err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (we)
            mem[we_addr] <= we_data;
    end

    assign ir_c = (busy || {1'b0, pc} >= CNT) ? '0 : mem[pc[AW-1:0]];

    generate
        if (REG_READ != 0) begin : g_reg
            logic [IR_WIDTH-1:0] ir_q;
            logic                ir_valid_q;
            always_ff @(posedge clk) begin
                if (res) begin
                    ir_q       <= '0;
                    ir_valid_q <= 1'b0;
                end else begin
                    ir_q       <= ir_c;
                    ir_valid_q <= !busy;
                end
            end
            assign ir       = ir_q;
            assign ir_valid = ir_valid_q;
        end else begin : g_comb
            assign ir       = ir_c;
            assign ir_valid = !busy;
        end
    endgenerate
endmodule

// File: tb/tb_prog_mem_loadable.sv
// tb_prog_mem_loadable: scoreboard bench driving a combinational-fetch and a
// registered-fetch instance from the same directed stimulus.
module tb_prog_mem_loadable;
    logic        clk = 0, res = 0, ld_start = 0, ld_valid = 0, ld_last = 0;
    logic [7:0]  pc = 0, ld_addr = 0, ld_data = 0;
    logic [15:0] ir0, ir1;
    logic        irv0, irv1, busy0, busy1, rdy0, rdy1, done0, done1, err0, err1;
    int          checks = 0, failures = 0;
    logic        fetch_req = 0;
    bit          pend1 = 0;
    logic [15:0] qf0[$], qf1[$];
    logic        qd0[$], qd1[$];

    always #5 clk = ~clk;

    prog_mem_loadable #(.REG_READ(0)) dut0 (
        .clk(clk), .res(res), .pc(pc), .ir(ir0), .ir_valid(irv0), .busy(busy0),
        .ld_start(ld_start), .ld_addr(ld_addr), .ld_valid(ld_valid), .ld_ready(rdy0),
        .ld_data(ld_data), .ld_last(ld_last), .ld_done(done0), .ld_err(err0));

    prog_mem_loadable #(.REG_READ(1)) dut1 (
        .clk(clk), .res(res), .pc(pc), .ir(ir1), .ir_valid(irv1), .busy(busy1),
        .ld_start(ld_start), .ld_addr(ld_addr), .ld_valid(ld_valid), .ld_ready(rdy1),
        .ld_data(ld_data), .ld_last(ld_last), .ld_done(done1), .ld_err(err1));

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic miss(input string name);
        checks++;
        failures++;
        $display("FAIL %s got=event exp=none", name);
    endtask

    // Combinational instance and done/err scoreboard, sampled just after the edge
    always @(posedge clk) begin
        #1;
        if (fetch_req) begin
            if (qf0.size() == 0) miss("fetch_comb_unexpected");
            else begin
                chk("ir_comb", ir0, qf0.pop_front());
                chk("ir_valid_comb", irv0, 1'b1);
            end
            pend1 = 1;
        end
        if (done0 === 1'b1) begin
            if (qd0.size() == 0) miss("ld_done0_unexpected");
            else chk("ld_err_at_done0", err0, qd0.pop_front());
        end
        if (done1 === 1'b1) begin
            if (qd1.size() == 0) miss("ld_done1_unexpected");
            else chk("ld_err_at_done1", err1, qd1.pop_front());
        end
    end

    // Registered instance is checked after pc has already moved on
    always @(negedge clk) begin
        #2;
        if (pend1) begin
            pend1 = 0;
            if (qf1.size() == 0) miss("fetch_reg_unexpected");
            else begin
                chk("ir_reg", ir1, qf1.pop_front());
                chk("ir_valid_reg", irv1, 1'b1);
            end
        end
    end

    task automatic fetch(input logic [7:0] a, input logic [15:0] exp);
        pc = a;
        fetch_req = 1;
        qf0.push_back(exp);
        qf1.push_back(exp);
        @(negedge clk);
        fetch_req = 0;
    endtask

    task automatic start(input logic [7:0] a);
        ld_start = 1;
        ld_addr = a;
        @(negedge clk);
        ld_start = 0;
    endtask

    task automatic beat(input logic [7:0] d, input logic last);
        int n = 0;
        ld_valid = 1;
        ld_data = d;
        ld_last = last;
        while (!rdy0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!rdy0) miss("beat_ready_timeout");
        @(negedge clk);
        ld_valid = 0;
        ld_last = 0;
    endtask

    task automatic expect_done(input logic err);
        qd0.push_back(err);
        qd1.push_back(err);
    endtask

    task automatic do_reset();
        int n = 0;
        res = 1;
        @(negedge clk);
        res = 0;
        chk("rst_busy0", busy0, 1'b1);
        chk("rst_busy1", busy1, 1'b1);
        chk("rst_ready0", rdy0, 1'b0);
        chk("rst_ready1", rdy1, 1'b0);
        chk("rst_err0", err0, 1'b0);
        chk("rst_err1", err1, 1'b0);
        chk("rst_done0", done0, 1'b0);
        chk("rst_irv0", irv0, 1'b0);
        chk("rst_irv1", irv1, 1'b0);
        chk("rst_ir0", ir0, 16'h0);
        chk("rst_ir1", ir1, 16'h0);
        while (busy0 && n < 300) begin
            n++;
            @(negedge clk);
        end
        chk("clear_cycles", n, 64);
        chk("busy1_after_clear", busy1, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
        for (int a = 0; a < 64; a++) fetch(8'(a), 16'h0000);
        fetch(8'd64, 16'h0000);
        fetch(8'd255, 16'h0000);

        expect_done(1'b0);
        start(8'd0);
        beat(8'h49, 0); beat(8'h03, 0); beat(8'h4A, 0); beat(8'h14, 1);
        @(negedge clk);
        fetch(8'd0, 16'h4903);
        fetch(8'd1, 16'h4A14);
        fetch(8'd2, 16'h0000);

        start(8'd70);
        chk("oob_err", err0, 1'b1);
        chk("oob_drain_ready", rdy0, 1'b1);
        expect_done(1'b1);
        beat(8'h55, 1);
        @(negedge clk);

        start(8'd10);
        chk("err_cleared_by_start", err0, 1'b0);
        expect_done(1'b1);
        beat(8'hA1, 0); beat(8'hB2, 0); beat(8'hC3, 1);
        @(negedge clk);
        fetch(8'd10, 16'hA1B2);
        fetch(8'd11, 16'h0000);

        start(8'd63);
        beat(8'h11, 0); beat(8'h22, 0);
        chk("err_before_overflow", err0, 1'b0);
        beat(8'h33, 0);
        chk("err_after_overflow0", err0, 1'b1);
        chk("err_after_overflow1", err1, 1'b1);
        chk("drain_ready", rdy0, 1'b1);
        chk("drain_busy", busy0, 1'b1);
        expect_done(1'b1);
        beat(8'h44, 1);
        @(negedge clk);
        fetch(8'd63, 16'h1122);
        fetch(8'd0, 16'h4903);

        start(8'd20);
        beat(8'h77, 0); beat(8'h88, 0); beat(8'h99, 0);
        do_reset();
        fetch(8'd0, 16'h0000);
        fetch(8'd1, 16'h0000);
        fetch(8'd10, 16'h0000);
        fetch(8'd20, 16'h0000);
        fetch(8'd63, 16'h0000);

        repeat (3) @(negedge clk);
        if (qf0.size() != 0 || qf1.size() != 0) miss("fetch_scoreboard_leftover");
        if (qd0.size() != 0 || qd1.size() != 0) miss("done_scoreboard_leftover");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
